// File: rtl/sirv_pwm_irq_gateway.sv
// Interrupt gateway for the PWM8 interrupt bus: per-source sync, level/edge capture,
// pending/in-flight/deferred tracking, and a claim/complete register port on ICB.
module sirv_pwm_irq_gateway #(
  parameter int NSRC        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] io_interrupts,
  input  logic            i_icb_cmd_valid,
  output logic            i_icb_cmd_ready,
  input  logic [31:0]     i_icb_cmd_addr,
  input  logic            i_icb_cmd_read,
  input  logic [31:0]     i_icb_cmd_wdata,
  output logic            i_icb_rsp_valid,
  input  logic            i_icb_rsp_ready,
  output logic [31:0]     i_icb_rsp_rdata,
  output logic            irq_o
);

  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_EDGE    = 2'd1;
  localparam logic [1:0] REG_PENDING = 2'd2;
  localparam logic [1:0] REG_CLAIM   = 2'd3;

  // ---------------------------------------------------------------------------
  // Source synchronisation and request generation
  // ---------------------------------------------------------------------------
  logic [NSRC-1:0] s;
  logic [NSRC-1:0] s_d;
  logic [NSRC-1:0] req;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = io_interrupts;
    end else begin : g_sync
      logic [NSRC-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
          end
        end else begin
          sync_q[0] <= io_interrupts;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d <= '0;
    end else begin
      s_d <= s;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers and per-source gateway state
  // ---------------------------------------------------------------------------
  logic [NSRC-1:0] enable_q;
  logic [NSRC-1:0] edge_q;
  logic [NSRC-1:0] pending_q;
  logic [NSRC-1:0] inflight_q;
  logic [NSRC-1:0] deferred_q;

  logic [NSRC-1:0] pending_n;
  logic [NSRC-1:0] inflight_n;
  logic [NSRC-1:0] deferred_n;

  // Edge mode uses the current synchronised sample against its one-cycle-old copy,
  // so rising detection costs no latency beyond the synchroniser itself.
  assign req = (edge_q & s & ~s_d) | (~edge_q & s);

  // ---------------------------------------------------------------------------
  // ICB command decode
  // Handshake: a command transfers on the cycle where cmd_valid & cmd_ready;
  // a response transfers on the cycle where rsp_valid & rsp_ready. rsp_valid
  // and rsp_rdata are held unchanged until that response transfer happens.
  // ---------------------------------------------------------------------------
  logic       cmd_fire;
  logic       rd_fire;
  logic       wr_fire;
  logic [1:0] reg_sel;
  logic       claim_cmd;
  logic       comp_cmd;
  logic [3:0] comp_id;

  assign i_icb_cmd_ready = ~i_icb_rsp_valid | i_icb_rsp_ready;
  assign cmd_fire        = i_icb_cmd_valid & i_icb_cmd_ready;
  assign rd_fire         = cmd_fire & i_icb_cmd_read;
  assign wr_fire         = cmd_fire & ~i_icb_cmd_read;
  assign reg_sel         = i_icb_cmd_addr[3:2];
  assign claim_cmd       = rd_fire & (reg_sel == REG_CLAIM);
  assign comp_cmd        = wr_fire & (reg_sel == REG_CLAIM);
  assign comp_id         = i_icb_cmd_wdata[3:0];

  // Only addr[3:2] and the low write-data bits carry meaning.
  logic unused_bits;
  assign unused_bits = ^{i_icb_cmd_addr, i_icb_cmd_wdata};

  // ---------------------------------------------------------------------------
  // Claim arbitration: lowest-index pending & enabled source wins
  // ---------------------------------------------------------------------------
  logic [NSRC-1:0] claimable;
  logic [3:0]      claim_id;
  logic [NSRC-1:0] claim_hit;
  logic [NSRC-1:0] comp_hit;

  assign claimable = pending_q & enable_q;

  always_comb begin
    claim_id = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (claimable[i]) begin
        claim_id = 4'(i + 1);
      end
    end
  end

  always_comb begin
    claim_hit = '0;
    comp_hit  = '0;
    for (int i = 0; i < NSRC; i++) begin
      claim_hit[i] = claim_cmd & (claim_id == 4'(i + 1));
      comp_hit[i]  = comp_cmd & (comp_id == 4'(i + 1)) & inflight_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Gateway next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_n  = pending_q;
    inflight_n = inflight_q;
    deferred_n = deferred_q;
    for (int i = 0; i < NSRC; i++) begin
      if (claim_hit[i]) begin
        pending_n[i]  = 1'b0;
        inflight_n[i] = 1'b1;
      end
      if (comp_hit[i]) begin
        inflight_n[i] = 1'b0;
        if (deferred_q[i]) begin
          pending_n[i]  = 1'b1;
          deferred_n[i] = req[i] & edge_q[i];
        end else if (req[i] & edge_q[i]) begin
          // An edge landing on the completion cycle would otherwise be stranded.
          pending_n[i] = 1'b1;
        end
      end else if (req[i] & ~pending_q[i] & ~inflight_q[i]) begin
        pending_n[i] = 1'b1;
      end else if (req[i] & edge_q[i]) begin
        deferred_n[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q   <= '0;
      edge_q     <= '0;
      pending_q  <= '0;
      inflight_q <= '0;
      deferred_q <= '0;
    end else begin
      pending_q  <= pending_n;
      inflight_q <= inflight_n;
      deferred_q <= deferred_n;
      if (wr_fire && reg_sel == REG_ENABLE) begin
        enable_q <= i_icb_cmd_wdata[NSRC-1:0];
      end
      if (wr_fire && reg_sel == REG_EDGE) begin
        edge_q <= i_icb_cmd_wdata[NSRC-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read data mux and registered response
  // ---------------------------------------------------------------------------
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = 32'd0;
    case (reg_sel)
      REG_ENABLE:  rd_mux[NSRC-1:0] = enable_q;
      REG_EDGE:    rd_mux[NSRC-1:0] = edge_q;
      REG_PENDING: rd_mux[NSRC-1:0] = pending_q;
      default:     rd_mux[3:0]      = claim_id;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_icb_rsp_valid <= 1'b0;
      i_icb_rsp_rdata <= 32'd0;
    end else begin
      if (cmd_fire) begin
        i_icb_rsp_valid <= 1'b1;
        i_icb_rsp_rdata <= i_icb_cmd_read ? rd_mux : 32'd0;
      end else if (i_icb_rsp_ready) begin
        i_icb_rsp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |claimable;
    end
  end

endmodule

// File: tb/tb_sirv_pwm_irq_gateway.sv
// Directed bench for sirv_pwm_irq_gateway: register access, level/edge gating,
// claim/complete, deferral, masking, back-to-back ICB traffic and stalled responses.
module tb_sirv_pwm_irq_gateway;

  localparam int NSRC        = 4;
  localparam int SYNC_STAGES = 2;

  logic            clk;
  logic            rst_n;
  logic [NSRC-1:0] io_interrupts;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [31:0]     cmd_addr;
  logic            cmd_read;
  logic [31:0]     cmd_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_rdata;
  logic            irq_o;

  int tests;
  int fails;

  sirv_pwm_irq_gateway #(.NSRC(NSRC), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .io_interrupts   (io_interrupts),
    .i_icb_cmd_valid (cmd_valid),
    .i_icb_cmd_ready (cmd_ready),
    .i_icb_cmd_addr  (cmd_addr),
    .i_icb_cmd_read  (cmd_read),
    .i_icb_cmd_wdata (cmd_wdata),
    .i_icb_rsp_valid (rsp_valid),
    .i_icb_rsp_ready (rsp_ready),
    .i_icb_rsp_rdata (rsp_rdata),
    .irq_o           (irq_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic icb_xfer(input logic [31:0] addr, input logic rd, input logic [31:0] wd,
                          output logic [31:0] data);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_read  = rd;
    cmd_wdata = wd;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      tests++;
      fails++;
      $display("FAIL icb_cmd_ready_timeout: ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    data = rsp_rdata;
  endtask

  task automatic icb_read(input logic [31:0] addr, output logic [31:0] data);
    icb_xfer(addr, 1'b1, 32'd0, data);
  endtask

  task automatic icb_write(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] unused_d;
    icb_xfer(addr, 1'b0, wd, unused_d);
  endtask

  task automatic pulse_src0();
    @(posedge clk); #1;
    io_interrupts[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    io_interrupts[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n         = 1'b0;
    io_interrupts = '0;
    cmd_valid     = 1'b0;
    cmd_addr      = '0;
    cmd_read      = 1'b0;
    cmd_wdata     = '0;
    rsp_ready     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (irq_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_outputs: irq=%b rsp_valid=%b cmd_ready=%b, required 0 0 1",
               irq_o, rsp_valid, cmd_ready);
    end
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_addr  = 32'(a * 4);
      cmd_read  = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0) begin
        fails++;
        $display("FAIL reset_read_%0d: rsp_valid=%b rdata=%h, required 1 00000000",
                 a, rsp_valid, rsp_rdata);
      end
    end
  endtask

  task automatic test_level();
    logic [31:0] d;
    icb_write(32'h0, 32'hF);
    icb_write(32'h4, 32'h0);
    io_interrupts = 4'b0100;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (irq_o !== 1'b0) begin
      fails++;
      $display("FAIL level_irq_early: irq=%b, required 0", irq_o);
    end
    @(posedge clk); #1;
    tests++;
    if (irq_o !== 1'b1) begin
      fails++;
      $display("FAIL level_irq_latency: irq=%b, required 1", irq_o);
    end
    icb_read(32'h8, d);
    tests++;
    if (d !== 32'h4) begin
      fails++;
      $display("FAIL level_pending: got %h, required 4", d);
    end
    icb_read(32'hC, d);
    tests++;
    if (d !== 32'd3) begin
      fails++;
      $display("FAIL level_claim: got %0d, required 3", d);
    end
    icb_read(32'h8, d);
    tests++;
    if (d !== 32'h0 || irq_o !== 1'b0) begin
      fails++;
      $display("FAIL level_after_claim: pending=%h irq=%b, required 0 0", d, irq_o);
    end
    icb_write(32'hC, 32'd3);
    @(posedge clk);
    icb_read(32'h8, d);
    tests++;
    if (d !== 32'h4) begin
      fails++;
      $display("FAIL level_reaccept: pending=%h, required 4", d);
    end
    io_interrupts = '0;
    repeat (4) @(posedge clk);
    icb_read(32'hC, d);
    icb_write(32'hC, 32'd3);
    @(posedge clk);
    icb_read(32'h8, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL level_cleanup: pending=%h, required 0", d);
    end
  endtask

  task automatic test_multi();
    logic [31:0] d;
    io_interrupts = 4'b1010;
    repeat (5) @(posedge clk);
    icb_read(32'hC, d);
    tests++;
    if (d !== 32'd2) begin
      fails++;
      $display("FAIL multi_claim_first: got %0d, required 2", d);
    end
    icb_read(32'hC, d);
    tests++;
    if (d !== 32'd4) begin
      fails++;
      $display("FAIL multi_claim_second: got %0d, required 4", d);
    end
    io_interrupts = '0;
    repeat (4) @(posedge clk);
    icb_write(32'hC, 32'd4);
    icb_write(32'hC, 32'd2);
    repeat (2) @(posedge clk);
    icb_read(32'h8, d);
    tests++;
    if (d !== 32'h0 || irq_o !== 1'b0) begin
      fails++;
      $display("FAIL multi_drained: pending=%h irq=%b, required 0 0", d, irq_o);
    end
  endtask

  task automatic test_edge_defer();
    logic [31:0] d;
    icb_write(32'h4, 32'h1);
    icb_read(32'h4, d);
    tests++;
    if (d !== 32'h1) begin
      fails++;
      $display("FAIL edge_reg_readback: got %h, required 1", d);
    end
    pulse_src0();
    repeat (3) @(posedge clk);
    icb_read(32'h8, d);
    tests++;
    if (d !== 32'h1) begin
      fails++;
      $display("FAIL edge_first_pending: got %h, required 1", d);
    end
    icb_read(32'hC, d);
    tests++;
    if (d !== 32'd1) begin
      fails++;
      $display("FAIL edge_first_claim: got %0d, required 1", d);
    end
    for (int p = 0; p < 3; p++) pulse_src0();
    repeat (3) @(posedge clk);
    icb_read(32'h8, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL edge_held_while_inflight: pending=%h, required 0", d);
    end
    icb_write(32'hC, 32'd1);
    icb_read(32'h8, d);
    tests++;
    if (d !== 32'h1) begin
      fails++;
      $display("FAIL edge_deferred_released: pending=%h, required 1", d);
    end
    icb_read(32'hC, d);
    tests++;
    if (d !== 32'd1) begin
      fails++;
      $display("FAIL edge_second_claim: got %0d, required 1", d);
    end
    icb_write(32'hC, 32'd1);
    repeat (2) @(posedge clk);
    icb_read(32'h8, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL edge_single_deferral: pending=%h, required 0", d);
    end
  endtask

  task automatic test_bad_complete();
    logic [31:0] d;
    pulse_src0();
    repeat (3) @(posedge clk);
    icb_read(32'hC, d);
    icb_write(32'hC, 32'd0);
    icb_write(32'hC, 32'd5);
    icb_write(32'hC, 32'd2);
    icb_read(32'hC, d);
    tests++;
    if (d !== 32'd0) begin
      fails++;
      $display("FAIL bad_complete_empty_claim: got %0d, required 0", d);
    end
    pulse_src0();
    repeat (3) @(posedge clk);
    icb_read(32'h8, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL bad_complete_still_inflight: pending=%h, required 0", d);
    end
    icb_write(32'hC, 32'd1);
    icb_read(32'h8, d);
    tests++;
    if (d !== 32'h1) begin
      fails++;
      $display("FAIL bad_complete_good_complete: pending=%h, required 1", d);
    end
    icb_read(32'hC, d);
    icb_write(32'hC, 32'd1);
  endtask

  task automatic test_enable_mask();
    logic [31:0] d;
    icb_write(32'h4, 32'h0);
    icb_write(32'h0, 32'h0);
    io_interrupts = 4'b0001;
    repeat (5) @(posedge clk);
    #1;
    icb_read(32'h8, d);
    tests++;
    if (d !== 32'h1 || irq_o !== 1'b0) begin
      fails++;
      $display("FAIL mask_pending_no_irq: pending=%h irq=%b, required 1 0", d, irq_o);
    end
    icb_read(32'hC, d);
    tests++;
    if (d !== 32'd0) begin
      fails++;
      $display("FAIL mask_claim_disabled: got %0d, required 0", d);
    end
    icb_write(32'h0, 32'h1);
    @(posedge clk); #1;
    tests++;
    if (irq_o !== 1'b1) begin
      fails++;
      $display("FAIL mask_enable_irq: irq=%b, required 1", irq_o);
    end
    icb_write(32'h0, 32'h0);
    @(posedge clk); #1;
    icb_read(32'h8, d);
    tests++;
    if (irq_o !== 1'b0 || d !== 32'h1) begin
      fails++;
      $display("FAIL mask_disable_keeps_pending: irq=%b pending=%h, required 0 1", irq_o, d);
    end
    icb_write(32'h0, 32'h1);
    icb_read(32'hC, d);
    io_interrupts = '0;
    repeat (4) @(posedge clk);
    icb_write(32'hC, 32'd1);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h5;
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b1 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: rsp_valid=%b cmd_ready=%b, required 1 1", rsp_valid, cmd_ready);
    end
    cmd_read = 1'b0; cmd_addr = 32'h4; cmd_wdata = 32'h3;
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0) begin
      fails++;
      $display("FAIL b2b_write_rsp: rsp_valid=%b rdata=%h, required 1 0", rsp_valid, rsp_rdata);
    end
    cmd_read = 1'b1; cmd_addr = 32'h4; cmd_wdata = 32'h0;
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h3) begin
      fails++;
      $display("FAIL b2b_read_edge: rsp_valid=%b rdata=%h, required 1 3", rsp_valid, rsp_rdata);
    end
    cmd_read = 1'b1; cmd_addr = 32'h0;
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5) begin
      fails++;
      $display("FAIL b2b_read_enable: rsp_valid=%b rdata=%h, required 1 5", rsp_valid, rsp_rdata);
    end
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: rsp_valid=%b, required 0", rsp_valid);
    end
    icb_write(32'h4, 32'h0);
    icb_write(32'h0, 32'hF);
  endtask

  task automatic test_stall_reset();
    logic [31:0] d;
    io_interrupts = 4'b0010;
    repeat (5) @(posedge clk);
    rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'hC;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd2) begin
      fails++;
      $display("FAIL stall_claim: rsp_valid=%b rdata=%h, required 1 2", rsp_valid, rsp_rdata);
    end
    io_interrupts = '0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      tests++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'd2) begin
        fails++;
        $display("FAIL stall_hold_%0d: cmd_ready=%b rsp_valid=%b rdata=%h, required 0 1 2",
                 k, cmd_ready, rsp_valid, rsp_rdata);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || irq_o !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_async_reset: rsp_valid=%b rdata=%h irq=%b cmd_ready=%b, required 0 0 0 1",
               rsp_valid, rsp_rdata, irq_o, cmd_ready);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    icb_read(32'h0, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL stall_enable_cleared: got %h, required 0", d);
    end
    icb_read(32'h8, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL stall_pending_cleared: got %h, required 0", d);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_level();
    test_multi();
    test_edge_defer();
    test_bad_complete();
    test_enable_mask();
    test_back_to_back();
    test_stall_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
